// File: rtl/tdp_pkg.sv
// tdp_pkg: types shared by tdp_burst_master and its output buffer.
//   - Default-width payload structs for the command, request and output streams.
//   - FSM state enum of the burst master. StWrAck is only reachable when
//     TDP_BURST_MASTER_WR_ACK_EN is defined.
package tdp_pkg;

  localparam int unsigned TDP_W_DATA = 16;
  localparam int unsigned TDP_W_ADDR = 16;
  localparam int unsigned TDP_W_LEN  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StWrIssue,
    StDrain,
    StWrAck
  } tdp_state_e;

  typedef struct packed {
    logic                  ctrl;  // 1 = write, 0 = read
    logic [TDP_W_DATA-1:0] data;
    logic [TDP_W_ADDR-1:0] addr;
  } tdp_req_t;

  typedef struct packed {
    logic                  wr;
    logic [TDP_W_LEN-1:0]  len;   // words - 1
    logic [TDP_W_ADDR-1:0] addr;
  } tdp_cmd_t;

  typedef struct packed {
    logic                  eot;
    logic [TDP_W_DATA-1:0] data;
  } tdp_dout_t;

endpackage

// File: rtl/tdp_burst_obuf.sv
// tdp_burst_obuf: one-entry registered valid/ready buffer that tags each word with
// an end-of-transaction flag. Sustains one word per cycle with one cycle latency.
// Ports:
//   clk, rst                    clock, synchronous active-high reset (drops the entry)
//   in_valid/in_ready/in_data   incoming read-data stream
//   in_eot                      eot flag captured together with in_data
//   out_valid/out_ready         outgoing stream handshake
//   out_data                    {eot, data}
module tdp_burst_obuf
  import tdp_pkg::*;
#(
  parameter int unsigned W_DATA = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] in_data,
  input  logic              in_eot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_DATA:0]   out_data
);

  logic            valid_q;
  logic [W_DATA:0] data_q;

  // Accept a new word whenever the slot is empty or is being drained this cycle.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= {in_eot, in_data};
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/tdp_burst_master.sv
// tdp_burst_master: turns {wr, len, addr} burst commands into single-word requests
// for one TDP RAM port and forwards read data downstream with an eot flag.
// Optional feature macro: TDP_BURST_MASTER_WR_ACK_EN adds the wr_ack stream
// (word count len+1) and the StWrAck state after each write burst.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd        burst command {wr, len, addr}
//   din_valid/din_ready/din        write data, consumed only by write requests
//   req_valid/req_ready/req        RAM request {ctrl, data, addr}, ctrl=1 write
//   rd_data_valid/_ready/rd_data   read data from the RAM port
//   wr_ack_valid/_ready/wr_ack     write burst completion (macro only)
//   dout_valid/dout_ready/dout     read results {eot, data}
module tdp_burst_master
  import tdp_pkg::*;
#(
  parameter int unsigned W_DATA    = 16,
  parameter int unsigned W_ADDR    = 16,
  parameter int unsigned W_LEN     = 8,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [W_LEN+W_ADDR:0]    cmd,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic [W_DATA-1:0]        din,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [W_DATA+W_ADDR:0]   req,
  input  logic                     rd_data_valid,
  output logic                     rd_data_ready,
  input  logic [W_DATA-1:0]        rd_data,
`ifdef TDP_BURST_MASTER_WR_ACK_EN
  output logic                     wr_ack_valid,
  input  logic                     wr_ack_ready,
  output logic [W_LEN:0]           wr_ack,
`endif
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [W_DATA:0]          dout
);

  localparam int unsigned W_OUTST = $clog2(MAX_OUTST + 1);
  localparam int unsigned W_CNT   = W_LEN + 1;

  typedef struct packed {
    logic              wr;
    logic [W_LEN-1:0]  len;
    logic [W_ADDR-1:0] addr;
  } cmd_t;

  typedef struct packed {
    logic              ctrl;
    logic [W_DATA-1:0] data;
    logic [W_ADDR-1:0] addr;
  } req_t;

  tdp_state_e         state_q, state_d;
  logic [W_ADDR-1:0]  addr_q, addr_d;
  logic [W_LEN-1:0]   len_q, len_d;
  logic [W_LEN-1:0]   issue_cnt_q, issue_cnt_d;
  logic [W_LEN-1:0]   resp_cnt_q, resp_cnt_d;
  logic [W_OUTST-1:0] outst_q, outst_d;

  cmd_t cmd_s;
  req_t req_s;
  logic req_hs, rd_hs, issue_rd, eot;

  assign cmd_s    = cmd;
  assign req      = req_s;
  assign req_hs   = req_valid && req_ready;
  assign rd_hs    = rd_data_valid && rd_data_ready;
  assign issue_rd = req_hs && (state_q == StRdIssue);
  assign eot      = (resp_cnt_q == len_q);

`ifdef TDP_BURST_MASTER_WR_ACK_EN
  assign wr_ack = W_CNT'(len_q) + W_CNT'(1);
`endif

  // Handshake outputs, decoded from the current state only.
  always_comb begin
    cmd_ready  = 1'b0;
    din_ready  = 1'b0;
    req_valid  = 1'b0;
    req_s.ctrl = 1'b0;
    req_s.data = '0;
    // Request address wraps silently modulo 2^W_ADDR.
    req_s.addr = addr_q + W_ADDR'(issue_cnt_q);
`ifdef TDP_BURST_MASTER_WR_ACK_EN
    wr_ack_valid = 1'b0;
`endif
    unique case (state_q)
      StIdle:    cmd_ready = 1'b1;
      StRdIssue: req_valid = (outst_q < W_OUTST'(MAX_OUTST));
      StWrIssue: begin
        req_valid  = din_valid;
        din_ready  = req_ready;
        req_s.ctrl = 1'b1;
        req_s.data = din;
      end
`ifdef TDP_BURST_MASTER_WR_ACK_EN
      StWrAck:   wr_ack_valid = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    outst_d     = outst_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d      = cmd_s.addr;
          len_d       = cmd_s.len;
          issue_cnt_d = '0;
          resp_cnt_d  = '0;
          state_d     = cmd_s.wr ? StWrIssue : StRdIssue;
        end
      end
      StRdIssue: begin
        if (rd_hs) resp_cnt_d = resp_cnt_q + W_LEN'(1);
        if (req_hs) begin
          issue_cnt_d = issue_cnt_q + W_LEN'(1);
          if (issue_cnt_q == len_q) state_d = StDrain;
        end
      end
      StWrIssue: begin
        if (req_hs) begin
          issue_cnt_d = issue_cnt_q + W_LEN'(1);
`ifdef TDP_BURST_MASTER_WR_ACK_EN
          if (issue_cnt_q == len_q) state_d = StWrAck;
`else
          if (issue_cnt_q == len_q) state_d = StIdle;
`endif
        end
      end
      StDrain: begin
        // Leave as the eot word enters the output buffer.
        if (rd_hs) begin
          resp_cnt_d = resp_cnt_q + W_LEN'(1);
          if (eot) state_d = StIdle;
        end
      end
`ifdef TDP_BURST_MASTER_WR_ACK_EN
      StWrAck: begin
        if (wr_ack_ready) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Simultaneous issue and response cancel out.
    if (issue_rd && !rd_hs) begin
      outst_d = outst_q + W_OUTST'(1);
    end else if (!issue_rd && rd_hs) begin
      outst_d = outst_q - W_OUTST'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      outst_q     <= outst_d;
    end
  end

  tdp_burst_obuf #(
    .W_DATA(W_DATA)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_data_valid),
    .in_ready (rd_data_ready),
    .in_data  (rd_data),
    .in_eot   (eot),
    .out_valid(dout_valid),
    .out_ready(dout_ready),
    .out_data (dout)
  );

`ifndef SYNTHESIS
  // A response word with no read in flight is a RAM-side protocol error.
  always_ff @(posedge clk) begin
    if (!rst && rd_hs) begin
      assert ((state_q == StRdIssue || state_q == StDrain) && outst_q != '0)
        else $error("tdp_burst_master: unexpected rd_data word");
    end
  end
`endif

endmodule

// File: tb/tb_tdp_burst_master.sv
// tb_tdp_burst_master: directed and randomized bursts against a RAM model; expected
// request and output streams are derived from a shadow memory and burst arithmetic.
module tb_tdp_burst_master;

  localparam int unsigned W_DATA    = 16;
  localparam int unsigned W_ADDR    = 8;
  localparam int unsigned W_LEN     = 8;
  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned DEPTH     = 1 << W_ADDR;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid, cmd_ready;
  logic [W_LEN+W_ADDR:0]  cmd;
  logic                   din_valid, din_ready;
  logic [W_DATA-1:0]      din;
  logic                   req_valid, req_ready;
  logic [W_DATA+W_ADDR:0] req;
  logic                   rd_data_valid, rd_data_ready;
  logic [W_DATA-1:0]      rd_data;
  logic                   dout_valid, dout_ready;
  logic [W_DATA:0]        dout;
`ifdef TDP_BURST_MASTER_WR_ACK_EN
  logic                   wr_ack_valid, wr_ack_ready;
  logic [W_LEN:0]         wr_ack;
  logic [W_LEN:0]         ack_log[$];
  int                     ack_base;
`endif

  always #5 clk = ~clk;

  tdp_burst_master #(
    .W_DATA   (W_DATA),
    .W_ADDR   (W_ADDR),
    .W_LEN    (W_LEN),
    .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd          (cmd),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .din          (din),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req          (req),
    .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready),
    .rd_data      (rd_data),
`ifdef TDP_BURST_MASTER_WR_ACK_EN
    .wr_ack_valid (wr_ack_valid),
    .wr_ack_ready (wr_ack_ready),
    .wr_ack       (wr_ack),
`endif
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout         (dout)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Stall controls written by the main sequence only.
  int req_rand, din_mode, dout_mode;

  // RAM model and observation logs, written by the environment process only.
  logic [W_DATA-1:0]      mem[DEPTH];
  logic [W_DATA-1:0]      resp_q[$];
  logic [W_DATA+W_ADDR:0] req_log[$];
  logic [W_DATA:0]        dout_log[$];
  int                     dout_cyc[$];
  int                     cyc, inflight, max_inflight, din_rd;
  logic                   din_tog;

  // Reference side, written by the main sequence only.
  logic [W_DATA-1:0]      ref_mem[DEPTH];
  logic [W_DATA-1:0]      din_q[$];
  logic [W_DATA-1:0]      wr_pat[$];
  logic [W_DATA+W_ADDR:0] exp_req[$];
  logic [W_DATA:0]        exp_dout[$];
  int                     req_base, dout_base, cur_len;
  logic                   cur_wr;

  // Environment: sample handshakes at negedge, drive new inputs just after posedge.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = W_DATA'(i + 'h100);
    rd_data_valid = 1'b0;
    rd_data       = '0;
    req_ready     = 1'b1;
    din_valid     = 1'b0;
    din           = '0;
    dout_ready    = 1'b1;
    din_tog       = 1'b0;
    cyc           = 0;
    inflight      = 0;
    max_inflight  = 0;
    din_rd        = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        resp_q.delete();
        inflight = 0;
      end else begin
        if (req_valid && req_ready) begin
          req_log.push_back(req);
          if (req[W_DATA+W_ADDR]) begin
            mem[req[W_ADDR-1:0]] = req[W_ADDR +: W_DATA];
          end else begin
            resp_q.push_back(mem[req[W_ADDR-1:0]]);
            inflight++;
          end
        end
        if (rd_data_valid && rd_data_ready) begin
          void'(resp_q.pop_front());
          inflight--;
        end
        if (inflight > max_inflight) max_inflight = inflight;
        if (din_valid && din_ready) din_rd++;
        if (dout_valid && dout_ready) begin
          dout_log.push_back(dout);
          dout_cyc.push_back(cyc);
        end
`ifdef TDP_BURST_MASTER_WR_ACK_EN
        if (wr_ack_valid && wr_ack_ready) ack_log.push_back(wr_ack);
`endif
      end
      @(posedge clk);
      #1;
      rd_data_valid = (resp_q.size() > 0);
      if (resp_q.size() > 0) rd_data = resp_q[0];
      else rd_data = '0;
      req_ready = (req_rand == 0) || ($urandom_range(0, 1) == 1);
      din_tog   = ~din_tog;
      if (din_rd < din_q.size()) begin
        din       = din_q[din_rd];
        din_valid = (din_mode == 0) || (din_mode == 1 && din_tog) ||
                    (din_mode == 2 && $urandom_range(0, 1) == 1);
      end else begin
        din       = '0;
        din_valid = 1'b0;
      end
      dout_ready = (dout_mode == 0) || (dout_mode == 2 && $urandom_range(0, 1) == 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Build the expected request/output streams of one burst from the shadow memory.
  task automatic prep(input logic wr, input int len, input int addr);
    logic [W_ADDR-1:0] a;
    logic [W_DATA-1:0] w;
    exp_req.delete();
    exp_dout.delete();
    req_base  = req_log.size();
    dout_base = dout_log.size();
    cur_wr    = wr;
    cur_len   = len;
`ifdef TDP_BURST_MASTER_WR_ACK_EN
    ack_base  = ack_log.size();
`endif
    for (int i = 0; i <= len; i++) begin
      a = W_ADDR'(addr + i);
      if (wr) begin
        if (wr_pat.size() > 0) w = wr_pat.pop_front();
        else w = W_DATA'($urandom);
        din_q.push_back(w);
        ref_mem[a] = w;
        exp_req.push_back({1'b1, w, a});
      end else begin
        exp_req.push_back({1'b0, {W_DATA{1'b0}}, a});
        exp_dout.push_back({(i == len), ref_mem[a]});
      end
    end
  endtask

  task automatic send_cmd();
    bit done = 1'b0;
    cmd       = {cur_wr, W_LEN'(cur_len), exp_req[0][W_ADDR-1:0]};
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = cmd_ready;
      @(posedge clk);
      #2;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", done, 1);
  endtask

  task automatic finish_burst(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      done = (req_log.size() - req_base >= exp_req.size()) &&
             (dout_log.size() - dout_base >= exp_dout.size()) && cmd_ready;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_nreq"}, req_log.size() - req_base, exp_req.size());
    check({tag, "_ndout"}, dout_log.size() - dout_base, exp_dout.size());
    for (int i = 0; i < exp_req.size(); i++) begin
      if (req_base + i < req_log.size())
        check($sformatf("%s_req%0d", tag, i), req_log[req_base+i], exp_req[i]);
    end
    for (int i = 0; i < exp_dout.size(); i++) begin
      if (dout_base + i < dout_log.size())
        check($sformatf("%s_dout%0d", tag, i), dout_log[dout_base+i], exp_dout[i]);
    end
    if (cur_wr) check({tag, "_din_used"}, din_rd, din_q.size());
`ifdef TDP_BURST_MASTER_WR_ACK_EN
    if (cur_wr) begin
      check({tag, "_nack"}, ack_log.size() - ack_base, 1);
      if (ack_log.size() > ack_base) check({tag, "_ack"}, ack_log[ack_base], cur_len + 1);
    end
`endif
  endtask

  initial begin
    logic [W_DATA:0] word;
    bit              reached;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = '0;
    req_rand  = 0;
    din_mode  = 0;
    dout_mode = 0;
`ifdef TDP_BURST_MASTER_WR_ACK_EN
    wr_ack_ready = 1'b1;
`endif
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = W_DATA'(i + 'h100);
    repeat (3) step();
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_req_valid", req_valid, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_din_ready", din_ready, 0);
    check("rst_rd_ready", rd_data_ready, 1);

    // Read burst with no stalls: one output word per cycle.
    prep(1'b0, 3, 'h10);
    send_cmd();
    finish_burst("rd0");
    for (int i = 1; i < 4; i++) begin
      if (dout_base + i < dout_cyc.size())
        check($sformatf("rd0_gap%0d", i), dout_cyc[dout_base+i] - dout_cyc[dout_base+i-1], 1);
    end

    // Outstanding limit: with dout stalled, MAX_OUTST in flight plus one buffered word.
    dout_mode = 1;
    prep(1'b0, 7, 'h40);
    send_cmd();
    repeat (20) step();
    check("ost_nreq_stalled", req_log.size() - req_base, MAX_OUTST + 1);
    check("ost_inflight", inflight, MAX_OUTST);
    check("ost_dout_valid", dout_valid, 1);
    dout_mode = 0;
    finish_burst("ost");

    // Address wrap at the top of the address space.
    prep(1'b0, 2, 'hFF);
    send_cmd();
    finish_burst("wrap");

    // Write with toggling din.valid and random req.ready, then read back.
    req_rand = 1;
    din_mode = 1;
    wr_pat.push_back(16'hAAAA);
    wr_pat.push_back(16'hBBBB);
    prep(1'b1, 1, 'h20);
    send_cmd();
    finish_burst("wb_wr");
    prep(1'b0, 1, 'h20);
    send_cmd();
    finish_burst("wb_rd");
    if (dout_log.size() >= dout_base + 2) begin
      check("wb_word0", dout_log[dout_base], 17'h0AAAA);
      check("wb_word1", dout_log[dout_base+1], 17'h1BBBB);
    end
    req_rand = 0;
    din_mode = 0;

    // Single-word read carries eot.
    prep(1'b0, 0, 'h05);
    send_cmd();
    finish_burst("one");
    if (dout_log.size() > dout_base) begin
      word = dout_log[dout_base];
      check("one_eot", word[W_DATA], 1);
    end

    // Reset mid-burst after two requests with a word held in the output buffer.
    dout_mode = 1;
    prep(1'b0, 5, 'h30);
    send_cmd();
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      reached = (req_log.size() - req_base >= 2);
      if (!reached) step();
    end
    check("rstb_two_reqs", reached, 1);
    check("rstb_dout_held", dout_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstb_cmd_ready", cmd_ready, 1);
    check("rstb_dout_valid", dout_valid, 0);
    check("rstb_req_valid", req_valid, 0);
    check("rstb_rd_ready", rd_data_ready, 1);
    dout_mode = 0;
    step();

    // Maximum burst length, wrapping through the address space.
    prep(1'b0, (1 << W_LEN) - 1, 'h80);
    send_cmd();
    finish_burst("maxlen");

    // Randomized bursts with random stalls on every stream.
    req_rand  = 1;
    din_mode  = 2;
    dout_mode = 2;
    for (int k = 0; k < 10; k++) begin
      prep(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, DEPTH - 1)));
      send_cmd();
      finish_burst($sformatf("rnd%0d", k));
    end

    check("outst_bound", max_inflight <= MAX_OUTST, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tdp_burst_master.md
Name: tdp_burst_master

Overview:
- Initiator-side counterpart of a TDP RAM port. Turns burst commands (base address, word count, read/write) into single-word request tokens on a dti request interface.
- Consumes the port's read-data stream and re-emits it downstream with an end-of-transaction flag.
- Sits between a DMA/control block and one TDP port; one instance per RAM port.

Parameters:
- W_DATA, 16, data word width; must match the RAM port.
- W_ADDR, 16, address width; must match the RAM port.
- W_LEN, 8, burst length field width (encodes words-1).
- MAX_OUTST, 4, maximum read requests in flight (issued, response not yet accepted); 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- cmd  dti.consumer  1+W_LEN+W_ADDR  {wr, len, addr}, wr at MSB, addr at LSB.
- din  dti.consumer  W_DATA  write data, consumed only during write bursts.
- req  dti.producer  1+W_DATA+W_ADDR  {ctrl, data, addr} to RAM port; ctrl=1 write, ctrl=0 read.
- rd_data  dti.consumer  W_DATA  read data returned by the RAM port.
- dout  dti.producer  1+W_DATA  {eot, data} read results to downstream.

Behaviour:
- Interfaces: clk and rst exactly as named; reset synchronous, active-high. Transfer on every dti interface occurs when valid && ready in the same cycle.
- Reset values: state=IDLE, all counters 0, req.valid=0, dout.valid=0, cmd.ready=1, din.ready=0, rd_data.ready=1.
- FSM states IDLE, RD_ISSUE, WR_ISSUE, DRAIN.
- IDLE:
  - cmd.ready=1.
  - On cmd handshake, latch addr, len and wr; clear issue_cnt and resp_cnt.
  - Next state is WR_ISSUE if wr=1, else RD_ISSUE.
- Request address: addr + issue_cnt, modulo 2^W_ADDR (wraps silently at the top).
- Burst size: len+1 words; len=0 is one word; len=2^W_LEN-1 is the maximum burst.
- RD_ISSUE:
  - req.valid = (outst < MAX_OUTST); ctrl=0; data field 0.
  - On req handshake, issue_cnt increments and outst increments.
  - After the handshake with issue_cnt==len, go to DRAIN.
- DRAIN:
  - No requests issued.
  - Go to IDLE in the cycle resp_cnt wraps past len, i.e. the handshake of the eot word into the output buffer.
- Response counting: outst decrements on each rd_data handshake. Simultaneous issue and response leaves outst unchanged.
- Output path (sub-module):
  - One-entry registered output buffer; rd_data.ready = !dout.valid || dout.ready.
  - Latency rd_data→dout is 1 cycle; full throughput of 1 word/cycle.
  - eot=1 on the word where resp_cnt==len.
- WR_ISSUE:
  - req.valid=din.valid; din.ready=req.ready; ctrl=1; data=din.data.
  - din is consumed only on req handshake.
  - After the handshake with issue_cnt==len, go to IDLE. Writes are posted; no response is expected.
- rd_data ready outside a read burst: rd_data.ready stays driven by the buffer. Any unexpected rd_data word is a protocol error and is flagged by a simulation assertion.
- Back-to-back commands: the earliest next cmd acceptance is the cycle after return to IDLE.
- Reset mid-burst: everything returns to IDLE immediately and the buffered dout word is dropped. The RAM port shares the reset, so no stale responses remain.

Optional Feature:
- Macro: TDP_BURST_MASTER_WR_ACK_EN.
- Defined:
  - Adds port wr_ack, dti.producer, W_LEN+1 bits, carrying the word count len+1.
  - After the final write handshake, the FSM enters state WR_ACK and holds wr_ack.valid until its handshake, then goes to IDLE. cmd is not accepted meanwhile.
- Undefined: the port and the state are absent; WR_ISSUE returns directly to IDLE.

Decomposition:
- tdp_pkg holds:
  - typedefs tdp_req_t {ctrl, data, addr}, tdp_cmd_t {wr, len, addr} and tdp_dout_t {eot, data}, parameterised via localparams of the instantiating module or by package parameters set to defaults;
  - the FSM state enum.
- Sub-module tdp_burst_obuf: one-entry registered dti buffer with eot insertion.

Test Plan:
- Read burst, zero stalls:
  - Stimulus: RAM preloaded mem[i]=i+0x100; cmd {wr=0,len=3,addr=0x10}; dout always ready.
  - Expected: requests to addr 0x10..0x13; dout 0x110,0x111,0x112,0x113 on consecutive cycles; eot only on 0x113.
- Outstanding limit:
  - Stimulus: MAX_OUTST=2; read len=7; dout.ready=0 for 20 cycles.
  - Expected: at most 2 requests beyond accepted responses; no data lost; 8 words in order after release.
- Address wrap:
  - Stimulus: W_ADDR=4; read {len=2,addr=0xF}.
  - Expected: request addresses 0xF,0x0,0x1; eot on the third word.
- Write then read back:
  - Stimulus: write {len=1,addr=0x20} with din 0xAAAA,0xBBBB, din.valid toggling every other cycle; then read {len=1,addr=0x20}.
  - Expected: dout 0xAAAA, then 0xBBBB with eot=1.
- Single word plus reset:
  - Stimulus: cmd len=0 read, giving one word with eot=1. Then assert rst during a len=5 read after 2 requests.
  - Expected: next cycle state IDLE, dout.valid=0, cmd.ready=1.
- Write ack, with TDP_BURST_MASTER_WR_ACK_EN defined:
  - Stimulus: write len=4.
  - Expected: wr_ack=5 after the fifth write; cmd.ready=0 until wr_ack handshake.
